// File: rtl/traffic_cmd_parser.sv
// traffic_cmd_parser: assembles framed bytes from a host/serial link into the
// cmd_type/cmd_valid/cmd_data bus consumed by traffic_lights.
//
// Frame: SYNC_BYTE, {5'b0, type[2:0]}, data[15:8], data[7:0] [, checksum]
// Optional feature macro: TRAFFIC_CMD_CHECKSUM_EN adds a fifth byte equal to
// the XOR of the type byte and both data bytes (mismatch -> error code 3).
//
// Ports:
//   clk_i         clock
//   arst_i        asynchronous active-high reset
//   byte_data_i   incoming byte
//   byte_valid_i  byte present (accepted when byte_valid_i && byte_ready_o)
//   byte_ready_o  parser can accept a byte (low only in the emit cycle)
//   cmd_type_o    command type, holds between strobes
//   cmd_valid_o   one-cycle command strobe
//   cmd_data_o    command payload, holds between strobes
//   err_o         one-cycle frame-rejection strobe
//   err_code_o    1 = bad type, 2 = timeout, 3 = checksum; holds between strobes
module traffic_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_TYPE       = 5,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic [2:0]  cmd_type_o,
  output logic        cmd_valid_o,
  output logic [15:0] cmd_data_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] ERR_TYPE    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
  localparam logic [1:0] ERR_CSUM    = 2'd3;
`endif

`ifdef TRAFFIC_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_TYPE, S_DATA_HI, S_DATA_LO, S_CSUM, S_EMIT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_TYPE, S_DATA_HI, S_DATA_LO, S_EMIT
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       type_q, type_d;
  logic [7:0]       data_hi_q, data_hi_d;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
  logic [7:0]       data_lo_q, data_lo_d;
  logic [7:0]       csum_c;
`endif

  logic        ready_d;
  logic [2:0]  cmd_type_d;
  logic        cmd_valid_d;
  logic [15:0] cmd_data_d;
  logic        err_d;
  logic [1:0]  err_code_d;

  logic accept_c;
  logic in_frame_c;

  assign accept_c = byte_valid_i && byte_ready_o;

`ifdef TRAFFIC_CMD_CHECKSUM_EN
  assign csum_c     = {5'b0, type_q} ^ data_hi_q ^ data_lo_q;
  assign in_frame_c = (state_q == S_TYPE) || (state_q == S_DATA_HI) ||
                      (state_q == S_DATA_LO) || (state_q == S_CSUM);
`else
  assign in_frame_c = (state_q == S_TYPE) || (state_q == S_DATA_HI) ||
                      (state_q == S_DATA_LO);
`endif

  // Next-state, counter and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    type_d      = type_q;
    data_hi_d   = data_hi_q;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
    data_lo_d   = data_lo_q;
`endif
    cmd_type_d  = cmd_type_o;
    cmd_valid_d = 1'b0;
    cmd_data_d  = cmd_data_o;
    err_d       = 1'b0;
    err_code_d  = err_code_o;

    // Stall timeout: an accepted byte arriving on the limit edge wins
    if (in_frame_c && !accept_c) begin
      if (cnt_q == CNT_LAST) begin
        state_d    = S_IDLE;
        cnt_d      = '0;
        err_d      = 1'b1;
        err_code_d = ERR_TIMEOUT;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (accept_c && (byte_data_i == SYNC_BYTE)) begin
          state_d = S_TYPE;
          cnt_d   = '0;
        end
      end
      S_TYPE: begin
        if (accept_c) begin
          cnt_d = '0;
          if ((byte_data_i[7:3] == 5'b0) &&
              (32'(byte_data_i[2:0]) <= MAX_TYPE)) begin
            state_d = S_DATA_HI;
            type_d  = byte_data_i[2:0];
          end else begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_TYPE;
          end
        end
      end
      S_DATA_HI: begin
        if (accept_c) begin
          state_d   = S_DATA_LO;
          cnt_d     = '0;
          data_hi_d = byte_data_i;
        end
      end
      S_DATA_LO: begin
        if (accept_c) begin
          cnt_d = '0;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
          state_d   = S_CSUM;
          data_lo_d = byte_data_i;
`else
          state_d     = S_EMIT;
          cmd_valid_d = 1'b1;
          cmd_type_d  = type_q;
          cmd_data_d  = {data_hi_q, byte_data_i};
`endif
        end
      end
`ifdef TRAFFIC_CMD_CHECKSUM_EN
      S_CSUM: begin
        if (accept_c) begin
          cnt_d = '0;
          if (byte_data_i == csum_c) begin
            state_d     = S_EMIT;
            cmd_valid_d = 1'b1;
            cmd_type_d  = type_q;
            cmd_data_d  = {data_hi_q, data_lo_q};
          end else begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
          end
        end
      end
`endif
      S_EMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    ready_d = (state_d != S_EMIT);
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      type_q       <= '0;
      data_hi_q    <= '0;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
      data_lo_q    <= '0;
`endif
      byte_ready_o <= 1'b0;
      cmd_type_o   <= '0;
      cmd_valid_o  <= 1'b0;
      cmd_data_o   <= '0;
      err_o        <= 1'b0;
      err_code_o   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      type_q       <= type_d;
      data_hi_q    <= data_hi_d;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
      data_lo_q    <= data_lo_d;
`endif
      byte_ready_o <= ready_d;
      cmd_type_o   <= cmd_type_d;
      cmd_valid_o  <= cmd_valid_d;
      cmd_data_o   <= cmd_data_d;
      err_o        <= err_d;
      err_code_o   <= err_code_d;
    end
  end

endmodule

// File: tb/tb_traffic_cmd_parser.sv
// Scoreboarded bench for traffic_cmd_parser: a frame-level reference model
// predicts commands/errors (with their cycle) into a queue; a negedge monitor
// pops and compares whenever the DUT strobes cmd_valid_o or err_o.
module tb_traffic_cmd_parser;

  localparam int unsigned T    = 20;
  localparam int unsigned MAXT = 5;
  localparam logic [7:0]  SYNC = 8'hA5;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic        clk_i;
  logic        arst_i;
  logic [7:0]  byte_data_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic [2:0]  cmd_type_o;
  logic        cmd_valid_o;
  logic [15:0] cmd_data_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  traffic_cmd_parser #(
    .TIMEOUT_CYCLES(T),
    .MAX_TYPE      (MAXT),
    .SYNC_BYTE     (SYNC)
  ) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .byte_data_i (byte_data_i),
    .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o),
    .cmd_type_o  (cmd_type_o),
    .cmd_valid_o (cmd_valid_o),
    .cmd_data_o  (cmd_data_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          is_err;
    logic [2:0]  typ;
    logic [15:0] data;
    logic [1:0]  code;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;

  // Reference model state: bytes of the frame in progress and idle gap length
  logic [7:0]  frame[$];
  int          gap;
  bit          exp_ready;
  logic [2:0]  exp_type;
  logic [15:0] exp_data;
  logic [1:0]  exp_code;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_err(logic [1:0] c);
    ev_t e;
    e.is_err = 1'b1; e.typ = '0; e.data = '0; e.code = c; e.cyc = cyc;
    exp_q.push_back(e);
    exp_code = c;
    frame.delete();
  endfunction

  function automatic void push_cmd(logic [2:0] t, logic [15:0] d);
    ev_t e;
    e.is_err = 1'b0; e.typ = t; e.data = d; e.code = '0; e.cyc = cyc;
    exp_q.push_back(e);
    exp_type = t;
    exp_data = d;
    frame.delete();
  endfunction

  // One clock edge of the frame-level model
  function automatic bit model_edge(bit v, logic [7:0] d);
    bit acc, emit;
    cyc++;
    acc  = v && exp_ready;
    emit = 1'b0;
    if (acc) begin
      if (frame.size() == 0) begin
        if (d == SYNC) begin
          frame.push_back(d);
          gap = 0;
        end
      end else begin
        frame.push_back(d);
        gap = 0;
        if (frame.size() == 2 && (d[7:3] != 5'd0 || 32'(d[2:0]) > MAXT)) begin
          push_err(2'd1);
        end else if (frame.size() == FLEN) begin
          if (FLEN == 5 && frame[FLEN-1] != (frame[1] ^ frame[2] ^ frame[3])) begin
            push_err(2'd3);
          end else begin
            push_cmd(frame[1][2:0], {frame[2], frame[3]});
            emit = 1'b1;
          end
        end
      end
    end else if (frame.size() > 0) begin
      gap++;
      if (gap == int'(T)) push_err(2'd2);
    end
    exp_ready = !emit;
    return acc;
  endfunction

  task automatic step(bit v, logic [7:0] d, output bit acc);
    byte_valid_i = v;
    byte_data_i  = d;
    @(posedge clk_i);
    acc = model_edge(v, d);
    #1;
  endtask

  task automatic send_byte(logic [7:0] d);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 3 && !acc; i++) step(1'b1, d, acc);
    byte_valid_i = 1'b0;
    if (!acc) check("byte_accept_timeout", byte_ready_o, 1'b1);
  endtask

  task automatic idle(int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), acc);
  endtask

  task automatic send_frame(logic [7:0] t, logic [15:0] d, bit bad_csum);
    logic [7:0] cs;
    cs = t ^ d[15:8] ^ d[7:0];
    if (bad_csum) cs = ~cs;
    send_byte(SYNC);
    send_byte(t);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    if (FLEN == 5) send_byte(cs);
  endtask

  task automatic do_reset();
    arst_i       = 1'b1;
    byte_valid_i = 1'b0;
    byte_data_i  = '0;
    frame.delete();
    exp_q.delete();
    gap       = 0;
    exp_ready = 1'b0;
    exp_type  = '0;
    exp_data  = '0;
    exp_code  = '0;
    @(posedge clk_i);
    #1;
    check("rst_ready", byte_ready_o, 1'b0);
    check("rst_valid", cmd_valid_o, 1'b0);
    check("rst_type", cmd_type_o, 3'd0);
    check("rst_data", cmd_data_o, 16'd0);
    check("rst_err", err_o, 1'b0);
    check("rst_code", err_code_o, 2'd0);
    arst_i = 1'b0;
  endtask

  // Monitor: every cycle out of reset compare held outputs and strobes
  always @(negedge clk_i) begin
    if (!arst_i) begin
      check("ready", byte_ready_o, exp_ready);
      check("both_strobes", cmd_valid_o & err_o, 1'b0);
      check("hold_type", cmd_type_o, exp_type);
      check("hold_data", cmd_data_o, exp_data);
      check("hold_code", err_code_o, exp_code);
      if (cmd_valid_o || err_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {cmd_valid_o, err_o}, 2'b00);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("ev_cycle", cyc, e.cyc);
          check("ev_is_err", err_o, e.is_err);
          if (e.is_err) check("err_code", err_code_o, e.code);
          else begin
            check("cmd_type", cmd_type_o, e.typ);
            check("cmd_data", cmd_data_o, e.data);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        ev_t e;
        e = exp_q.pop_front();
        check("missed_event_cycle", cyc + 1, e.cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    do_reset();
    idle(1);

    // Basic frame, then junk followed by a frame
    send_frame(8'h02, 16'h01F4, 1'b0);
    idle(2);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'h01, 16'h000A, 1'b0);
    idle(2);

    // Reserved type, then sync accepted in the error cycle
    send_byte(SYNC);
    send_byte(8'h06);
    send_byte(SYNC);
    check("sync_after_err_in_frame", frame.size(), 1);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h11);
    if (FLEN == 5) send_byte(8'h03 ^ 8'h00 ^ 8'h11);
    idle(2);

    // Stall timeout, then a frame whose payload contains the sync value
    send_byte(SYNC);
    send_byte(8'h03);
    idle(T);
    send_frame(8'h03, 16'h00A5, 1'b0);
    idle(2);

    // Gap one short of the limit is tolerated
    send_byte(SYNC);
    idle(T - 1);
    send_byte(8'h04);
    send_byte(8'h55);
    send_byte(8'hAA);
    if (FLEN == 5) send_byte(8'h04 ^ 8'h55 ^ 8'hAA);
    idle(2);

    // Reset mid-frame
    send_byte(SYNC);
    send_byte(8'h04);
    send_byte(8'h12);
    do_reset();
    send_frame(8'h01, 16'h1234, 1'b0);
    idle(2);

`ifdef TRAFFIC_CMD_CHECKSUM_EN
    send_frame(8'h02, 16'h01F4, 1'b1);
    idle(2);
`endif

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      int k;
      k = int'($urandom_range(0, 19));
      if (k < 3) begin
        step(1'b1, 8'($urandom), acc);
      end else if (k < 15) begin
        logic [7:0]  t;
        logic [15:0] d;
        logic [7:0]  cs;
        t  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : {5'b0, 3'($urandom)};
        d  = 16'($urandom);
        cs = t ^ d[15:8] ^ d[7:0];
        if ($urandom_range(0, 5) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
        send_byte(SYNC);
        if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(T - 2, T + 1)));
        send_byte(t);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 3)));
        send_byte(d[15:8]);
        send_byte(d[7:0]);
        if (FLEN == 5) send_byte(cs);
      end else if (k < 19) begin
        idle(int'($urandom_range(0, 4)));
      end else begin
        do_reset();
      end
    end

    idle(T + 3);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
